cache_assoc: RTL and testbench

CACHE_ASSOC -- requirements
Module: cache_assoc

---
 rtl/cache_pkg.sv | 9 +
 rtl/cache_way.sv | 49 ++++
 rtl/cache_assoc.sv | 160 ++++++++++++++++
 tb/tb_cache_assoc.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared types and default sizes for the 2-way set-associative cache.
package cache_pkg;
  localparam int ADDR_W_DEF  = 6;
  localparam int DATA_W_DEF  = 8;
  localparam int INDEX_W_DEF = 3;
  localparam int CNT_W       = 16;

  typedef enum logic [1:0] {S_IDLE, S_WB, S_FILL, S_RESP} state_t;
endpackage

// File: rtl/cache_way.sv
// One cache way: valid/dirty/tag/data per set, async read port, one write port.
module cache_way #(
  parameter int INDEX_W = 3,
  parameter int TAG_W   = 3,
  parameter int DATA_W  = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [INDEX_W-1:0] rd_idx,
  output logic               rd_valid,
  output logic               rd_dirty,
  output logic [TAG_W-1:0]   rd_tag,
  output logic [DATA_W-1:0]  rd_data,
  input  logic               wr_en,
  input  logic [INDEX_W-1:0] wr_idx,
  input  logic               wr_valid,
  input  logic               wr_dirty,
  input  logic [TAG_W-1:0]   wr_tag,
  input  logic [DATA_W-1:0]  wr_data
);
  localparam int SETS = 1 << INDEX_W;

  logic [SETS-1:0]             valid, dirty;
  logic [SETS-1:0][TAG_W-1:0]  tag;
  logic [SETS-1:0][DATA_W-1:0] data;

  // Only the state bits need reset; tag/data are qualified by valid.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid <= '0;
      dirty <= '0;
    end else if (wr_en) begin
      valid[wr_idx] <= wr_valid;
      dirty[wr_idx] <= wr_dirty;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag[wr_idx]  <= wr_tag;
      data[wr_idx] <= wr_data;
    end
  end

  assign rd_valid = valid[rd_idx];
  assign rd_dirty = dirty[rd_idx];
  assign rd_tag   = tag[rd_idx];
  assign rd_data  = data[rd_idx];
endmodule

// File: rtl/cache_assoc.sv
// 2-way set-associative write-back, write-allocate cache with LRU replacement
// and saturating hit/miss counters.
module cache_assoc
  import cache_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int INDEX_W = INDEX_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              rwb,
  input  logic [ADDR_W-1:0] adr,
  input  logic [DATA_W-1:0] data,
  output logic              cpu_ready,
  output logic [DATA_W-1:0] read_data,
  output logic              hit,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_adr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic [CNT_W-1:0]  hit_cnt,
  output logic [CNT_W-1:0]  miss_cnt
);
  localparam int TAG_W = ADDR_W - INDEX_W;
  localparam int SETS  = 1 << INDEX_W;

  state_t              state;
  logic [ADDR_W-1:0]   lat_adr;
  logic                lat_rwb;
  logic [DATA_W-1:0]   lat_data, resp_data;
  logic                vic_q;
  logic [SETS-1:0]     lru;

  logic [INDEX_W-1:0]  cur_idx, lat_idx, rd_idx, wr_idx;
  logic [TAG_W-1:0]    cur_tag, lat_tag, wr_tag;
  logic [1:0]          rd_valid, rd_dirty, way_hit, wr_en;
  logic [1:0][TAG_W-1:0]  rd_tag;
  logic [1:0][DATA_W-1:0] rd_data;
  logic [DATA_W-1:0]   wr_data;
  logic                wr_dirty, hit_way, hit_any, vic, vic_dirty;

  assign cur_idx = adr[INDEX_W-1:0];
  assign cur_tag = adr[ADDR_W-1:INDEX_W];
  assign lat_idx = lat_adr[INDEX_W-1:0];
  assign lat_tag = lat_adr[ADDR_W-1:INDEX_W];
  // Outside IDLE the arrays are looked up at the latched set so the victim stays visible.
  assign rd_idx  = (state == S_IDLE) ? cur_idx : lat_idx;

  for (genvar g = 0; g < 2; g++) begin : g_way
    cache_way #(.INDEX_W(INDEX_W), .TAG_W(TAG_W), .DATA_W(DATA_W)) u_way (
      .clk(clk), .reset(reset), .rd_idx(rd_idx),
      .rd_valid(rd_valid[g]), .rd_dirty(rd_dirty[g]), .rd_tag(rd_tag[g]), .rd_data(rd_data[g]),
      .wr_en(wr_en[g]), .wr_idx(wr_idx), .wr_valid(1'b1), .wr_dirty(wr_dirty),
      .wr_tag(wr_tag), .wr_data(wr_data)
    );
    assign way_hit[g] = rd_valid[g] && (rd_tag[g] == cur_tag);
  end

  assign hit_any   = (state == S_IDLE) && cpu_req && (|way_hit);
  assign hit       = hit_any;
  assign hit_way   = way_hit[1];
  assign vic       = !rd_valid[0] ? 1'b0 : (!rd_valid[1] ? 1'b1 : lru[cur_idx]);
  assign vic_dirty = rd_valid[vic] && rd_dirty[vic];

  assign cpu_ready = hit_any || (state == S_RESP);
  assign read_data = (state == S_RESP) ? resp_data : rd_data[hit_way];
  assign mem_req   = (state == S_WB) || (state == S_FILL);
  assign mem_we    = (state == S_WB);
  assign mem_adr   = (state == S_WB) ? {rd_tag[vic_q], lat_idx} : lat_adr;
  assign mem_wdata = rd_data[vic_q];

  always_comb begin
    wr_en    = '0;
    wr_idx   = lat_idx;
    wr_tag   = lat_tag;
    wr_data  = lat_data;
    wr_dirty = 1'b1;
    case (state)
      S_IDLE: begin
        wr_idx  = cur_idx;
        wr_tag  = cur_tag;
        wr_data = data;
        if (cpu_req && !rwb) begin
          if (|way_hit)        wr_en[hit_way] = 1'b1;
          else if (!vic_dirty) wr_en[vic]     = 1'b1;
        end
      end
      S_WB: if (mem_ack) begin
        wr_en[vic_q] = 1'b1;
        // A read keeps the written-back line, just clean; a write installs over it.
        if (lat_rwb) begin
          wr_tag   = rd_tag[vic_q];
          wr_data  = rd_data[vic_q];
          wr_dirty = 1'b0;
        end
      end
      S_FILL: if (mem_ack) begin
        wr_en[vic_q] = 1'b1;
        wr_data      = mem_rdata;
        wr_dirty     = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      lat_adr   <= '0;
      lat_rwb   <= 1'b0;
      lat_data  <= '0;
      resp_data <= '0;
      vic_q     <= 1'b0;
      lru       <= '0;
      hit_cnt   <= '0;
      miss_cnt  <= '0;
    end else begin
      case (state)
        S_IDLE: if (cpu_req) begin
          if (|way_hit) begin
            lru[cur_idx] <= ~hit_way;
            if (hit_cnt != '1) hit_cnt <= hit_cnt + CNT_W'(1);
          end else begin
            lat_adr  <= adr;
            lat_rwb  <= rwb;
            lat_data <= data;
            vic_q    <= vic;
            if (miss_cnt != '1) miss_cnt <= miss_cnt + CNT_W'(1);
            if (vic_dirty) state <= S_WB;
            else if (rwb)  state <= S_FILL;
            else begin
              resp_data <= data;
              state     <= S_RESP;
            end
          end
        end
        S_WB: if (mem_ack) begin
          if (lat_rwb) state <= S_FILL;
          else begin
            resp_data <= lat_data;
            state     <= S_RESP;
          end
        end
        S_FILL: if (mem_ack) begin
          resp_data <= mem_rdata;
          state     <= S_RESP;
        end
        S_RESP: begin
          lru[lat_idx] <= ~vic_q;
          state        <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cache_assoc.sv
// Directed bench for cache_assoc: miss/fill, hits, write-back eviction,
// delayed ack, async reset mid-fill and counter saturation.
module tb_cache_assoc;
  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req, rwb;
  logic [5:0]  adr;
  logic [7:0]  data;
  logic        cpu_ready, hit, mem_req, mem_we, mem_ack;
  logic [7:0]  read_data, mem_wdata, mem_rdata;
  logic [5:0]  mem_adr;
  logic [15:0] hit_cnt, miss_cnt;
  int checks = 0;
  int errors = 0;

  cache_assoc dut (
    .clk(clk), .reset(reset), .cpu_req(cpu_req), .rwb(rwb), .adr(adr), .data(data),
    .cpu_ready(cpu_ready), .read_data(read_data), .hit(hit),
    .mem_req(mem_req), .mem_we(mem_we), .mem_adr(mem_adr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic r, input logic [5:0] a, input logic [7:0] d);
    cpu_req = 1'b1; rwb = r; adr = a; data = d;
    #1;
  endtask

  task automatic ack(input logic [7:0] d);
    mem_ack = 1'b1; mem_rdata = d;
    tick();
    mem_ack = 1'b0;
    #1;
  endtask

  initial begin
    reset = 1'b0; cpu_req = 1'b0; rwb = 1'b1; adr = '0; data = '0;
    mem_ack = 1'b0; mem_rdata = '0;
    #12;
    chk("rst_ready",  32'(cpu_ready), 0);
    chk("rst_memreq", 32'(mem_req),   0);
    chk("rst_hitcnt", 32'(hit_cnt),   0);
    chk("rst_miscnt", 32'(miss_cnt),  0);
    reset = 1'b1;
    tick();

    // Cold read miss on 0x0D, fill with 0xA5
    req(1'b1, 6'h0D, 8'h00);
    chk("m1_hit",   32'(hit),       0);
    chk("m1_ready", 32'(cpu_ready), 0);
    tick();
    chk("m1_memreq", 32'(mem_req),  1);
    chk("m1_memwe",  32'(mem_we),   0);
    chk("m1_memadr", 32'(mem_adr),  'h0D);
    chk("m1_ready2", 32'(cpu_ready), 0);
    chk("m1_miscnt", 32'(miss_cnt), 1);
    ack(8'hA5);
    chk("m1_resp_rdy", 32'(cpu_ready), 1);
    chk("m1_resp_dat", 32'(read_data), 'hA5);
    chk("m1_resp_mr",  32'(mem_req),   0);
    tick(); cpu_req = 1'b0; #1;
    chk("idle_ready", 32'(cpu_ready), 0);
    req(1'b1, 6'h0D, 8'h00);
    chk("h1_hit",   32'(hit),       1);
    chk("h1_ready", 32'(cpu_ready), 1);
    chk("h1_data",  32'(read_data), 'hA5);
    tick(); cpu_req = 1'b0; #1;
    chk("h1_hitcnt", 32'(hit_cnt), 1);

    // Fill set 5 with two dirty lines, then evict by writing 0x15
    req(1'b0, 6'h05, 8'h11);
    chk("w05_ready", 32'(cpu_ready), 0);
    chk("w05_memreq", 32'(mem_req),  0);
    tick();
    chk("w05_resp",  32'(cpu_ready), 1);
    chk("w05_mr",    32'(mem_req),   0);
    tick(); cpu_req = 1'b0; #1;
    req(1'b0, 6'h0D, 8'h22);
    chk("w0d_hit",   32'(hit),       1);
    chk("w0d_ready", 32'(cpu_ready), 1);
    chk("w0d_mr",    32'(mem_req),   0);
    tick(); cpu_req = 1'b0; #1;
    req(1'b0, 6'h15, 8'h33);
    chk("w15_ready", 32'(cpu_ready), 0);
    tick();
    chk("w15_wb_req", 32'(mem_req),   1);
    chk("w15_wb_we",  32'(mem_we),    1);
    chk("w15_wb_adr", 32'(mem_adr),   'h05);
    chk("w15_wb_dat", 32'(mem_wdata), 'h11);
    ack(8'h00);
    chk("w15_resp", 32'(cpu_ready), 1);
    chk("w15_nofill", 32'(mem_req), 0);
    tick(); cpu_req = 1'b0; #1;
    chk("w15_miscnt", 32'(miss_cnt), 3);

    // 0x0D still resident; 0x05 evicts the dirty 0x15 line
    req(1'b1, 6'h0D, 8'h00);
    chk("r0d_hit",  32'(hit),       1);
    chk("r0d_data", 32'(read_data), 'h22);
    tick(); cpu_req = 1'b0; #1;
    chk("r0d_hitcnt", 32'(hit_cnt), 3);
    req(1'b1, 6'h05, 8'h00);
    chk("r05_hit", 32'(hit), 0);
    tick();
    chk("r05_wb_we",  32'(mem_we),    1);
    chk("r05_wb_adr", 32'(mem_adr),   'h15);
    chk("r05_wb_dat", 32'(mem_wdata), 'h33);
    ack(8'h00);
    chk("r05_fill_req", 32'(mem_req), 1);
    chk("r05_fill_we",  32'(mem_we),  0);
    chk("r05_fill_adr", 32'(mem_adr), 'h05);
    ack(8'h11);
    chk("r05_resp", 32'(cpu_ready), 1);
    chk("r05_data", 32'(read_data), 'h11);
    tick(); cpu_req = 1'b0; #1;
    chk("r05_miscnt", 32'(miss_cnt), 4);

    // Fill held off for 3 cycles
    req(1'b1, 6'h02, 8'h00);
    tick();
    for (int i = 0; i < 4; i++) begin
      chk("dly_req",   32'(mem_req),   1);
      chk("dly_adr",   32'(mem_adr),   'h02);
      chk("dly_we",    32'(mem_we),    0);
      chk("dly_ready", 32'(cpu_ready), 0);
      if (i < 3) tick();
    end
    ack(8'h5C);
    chk("dly_resp", 32'(cpu_ready), 1);
    chk("dly_data", 32'(read_data), 'h5C);
    tick(); cpu_req = 1'b0; #1;

    // Async reset during a fill
    req(1'b1, 6'h03, 8'h00);
    tick();
    chk("rf_req", 32'(mem_req), 1);
    reset = 1'b0; #1;
    chk("rf_req_drop", 32'(mem_req),   0);
    chk("rf_ready",    32'(cpu_ready), 0);
    chk("rf_miscnt",   32'(miss_cnt),  0);
    chk("rf_hitcnt",   32'(hit_cnt),   0);
    #1 reset = 1'b1; #1;
    chk("rf_rehit", 32'(hit), 0);
    tick();
    chk("rf_refill", 32'(mem_req), 1);
    chk("rf_readr",  32'(mem_adr), 'h03);
    ack(8'h77);
    chk("rf_data", 32'(read_data), 'h77);
    tick(); cpu_req = 1'b0; #1;

    // Hit counter saturation
    req(1'b1, 6'h03, 8'h00);
    for (int i = 0; i < 65535; i++) tick();
    chk("sat_hit", 32'(hit_cnt), 'hFFFF);
    for (int i = 0; i < 5; i++) tick();
    chk("sat_hold", 32'(hit_cnt), 'hFFFF);
    cpu_req = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
